// File: rtl/bcd_6d_to_binary_20b.sv
// Sequential BCD-to-binary converter: one decimal digit per clock, most significant first,
// with a start/busy/done handshake and a sticky invalid-digit flag.
module bcd_6d_to_binary_20b #(
    parameter int NDIG = 6,
    parameter int BW   = 20
) (
    input  logic                clk,
    input  logic                rstn_signal,
    input  logic                start,
    input  logic [4*NDIG-1:0]   bcd_i,
    output logic                busy,
    output logic                done,
    output logic [BW-1:0]       bin_o,
    output logic                err
);

    localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    // A BCD nibble is legal only in the range 0..9.
    function automatic logic digit_invalid(input logic [3:0] d);
        digit_invalid = (d > 4'd9);
    endfunction

    state_t              state_q, state_d;
    logic [4*NDIG-1:0]   bcd_q, bcd_d;
    logic [BW-1:0]       acc_q, acc_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                err_int_q, err_int_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [BW-1:0]       bin_q, bin_d;
    logic                err_q, err_d;

    logic [3:0]          digit_s;
    logic [BW+3:0]       acc_ext_s;
    logic [BW+3:0]       sum_s;
    logic                err_int_nx_s;

    // Multiply-by-10-and-add step on the currently selected digit.
    always_comb begin
        digit_s      = bcd_q[{cnt_q, 2'b00} +: 4];
        acc_ext_s    = {4'b0000, acc_q};
        sum_s        = (acc_ext_s << 3) + (acc_ext_s << 1) + {{BW{1'b0}}, digit_s};
        err_int_nx_s = err_int_q | digit_invalid(digit_s);
    end

    // Next-state and output computation for the IDLE/CONV sequencer.
    always_comb begin
        state_d   = state_q;
        bcd_d     = bcd_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        err_int_d = err_int_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        bin_d     = bin_q;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    bcd_d     = bcd_i;
                    acc_d     = {BW{1'b0}};
                    err_int_d = 1'b0;
                    cnt_d     = CW'(NDIG - 1);
                    busy_d    = 1'b1;
                    err_d     = 1'b0;
                    state_d   = CONV;
                end else begin
                    state_d = IDLE;
                end
            end
            CONV: begin
                acc_d     = sum_s[BW-1:0];
                err_int_d = err_int_nx_s;
                if (cnt_q == {CW{1'b0}}) begin
                    // A bad digit anywhere discards the whole result.
                    bin_d   = err_int_nx_s ? {BW{1'b0}} : sum_s[BW-1:0];
                    err_d   = err_int_nx_s;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rstn_signal) begin
        if (!rstn_signal) begin
            state_q   <= IDLE;
            bcd_q     <= {(4*NDIG){1'b0}};
            acc_q     <= {BW{1'b0}};
            cnt_q     <= {CW{1'b0}};
            err_int_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bin_q     <= {BW{1'b0}};
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bcd_q     <= bcd_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            err_int_q <= err_int_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            bin_q     <= bin_d;
            err_q     <= err_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign bin_o = bin_q;
    assign err   = err_q;

endmodule

// File: tb/tb_bcd_6d_to_binary_20b.sv
// Self-checking bench for bcd_6d_to_binary_20b: directed spec cases plus random
// conversions compared against a plain-arithmetic decimal model.
module tb_bcd_6d_to_binary_20b;

    logic        clk;
    logic        rstn_signal;
    logic        start;
    logic [23:0] bcd_i;
    logic        busy;
    logic        done;
    logic [19:0] bin_o;
    logic        err;

    int          n_checks;
    int          n_errors;
    logic [19:0] prev_bin;

    bcd_6d_to_binary_20b #(.NDIG(6), .BW(20)) dut (
        .clk         (clk),
        .rstn_signal (rstn_signal),
        .start       (start),
        .bcd_i       (bcd_i),
        .busy        (busy),
        .done        (done),
        .bin_o       (bin_o),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic ref_err(input logic [23:0] b);
        logic [23:0] t;
        logic        e;
        t = b;
        e = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (t[3:0] > 4'd9) e = 1'b1;
            t = t >> 4;
        end
        return e;
    endfunction

    function automatic logic [19:0] ref_bin(input logic [23:0] b);
        int          val;
        int          scale;
        logic [23:0] t;
        val   = 0;
        scale = 1;
        t     = b;
        for (int i = 0; i < 6; i++) begin
            val   = val + int'(t[3:0]) * scale;
            scale = scale * 10;
            t     = t >> 4;
        end
        if (ref_err(b)) return 20'd0;
        return val[19:0];
    endfunction

    task automatic do_conv(input logic [23:0] v);
        int cyc;
        @(negedge clk);
        bcd_i = v;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_eq("accept_busy", busy, 1);
        check_eq("accept_err_clr", err, 0);
        check_eq("accept_bin_hold", bin_o, prev_bin);
        bcd_i = $urandom;
        cyc = 0;
        while (!done && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check_eq("latency", cyc, 6);
        check_eq("bin", bin_o, ref_bin(v));
        check_eq("err", err, ref_err(v));
        check_eq("busy_at_done", busy, 0);
        prev_bin = ref_bin(v);
        @(posedge clk);
        #1;
        check_eq("done_pulse", done, 0);
        check_eq("bin_held", bin_o, prev_bin);
        check_eq("err_held", err, ref_err(v));
    endtask

    initial begin
        int          ndone;
        int          t_done[$];
        int          cyc;
        logic [23:0] rv;

        n_checks    = 0;
        n_errors    = 0;
        prev_bin    = 20'd0;
        rstn_signal = 1'b0;
        start       = 1'b0;
        bcd_i       = 24'h000000;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_bin", bin_o, 0);
        check_eq("rst_err", err, 0);
        @(negedge clk);
        rstn_signal = 1'b1;

        do_conv(24'h123456);
        do_conv(24'h999999);
        do_conv(24'h000000);
        do_conv(24'h000007);
        do_conv(24'h12A456);
        do_conv(24'h000042);
        do_conv(24'h00000F);

        // Start while busy is ignored; bcd_i changes mid-conversion are ignored.
        @(negedge clk);
        bcd_i = 24'h000100;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 2) begin
                start = 1'b1;
                bcd_i = 24'h999999;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                ndone++;
                check_eq("collide_bin", bin_o, 20'h00064);
                check_eq("collide_busy", busy, 0);
            end
        end
        check_eq("collide_ndone", ndone, 1);
        prev_bin = 20'h00064;

        // start held high: a conversion every 7 cycles.
        @(negedge clk);
        bcd_i = 24'h000010;
        start = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) begin
                t_done.push_back(i);
                check_eq("b2b_bin", bin_o, 20'h0000A);
                check_eq("b2b_busy", busy, 0);
            end
        end
        start = 1'b0;
        check_eq("b2b_count", t_done.size(), 4);
        for (int i = 1; i < t_done.size(); i++)
            check_eq("b2b_gap", t_done[i] - t_done[i-1], 7);
        cyc = 0;
        while (busy && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("b2b_drain", busy, 0);
        @(negedge clk);
        prev_bin = 20'h0000A;

        // Reset during a conversion aborts it at once.
        bcd_i = 24'h555555;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rstn_signal = 1'b0;
        #1;
        check_eq("abort_busy", busy, 0);
        check_eq("abort_done", done, 0);
        check_eq("abort_bin", bin_o, 0);
        check_eq("abort_err", err, 0);
        repeat (2) @(negedge clk);
        rstn_signal = 1'b1;
        prev_bin = 20'd0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_eq("abort_no_done", done, 0);
        end
        do_conv(24'h000001);

        // Random conversions, mostly legal digits with occasional bad nibbles.
        for (int n = 0; n < 40; n++) begin
            rv = 24'h000000;
            for (int d = 0; d < 6; d++) begin
                if ($urandom_range(0, 15) == 0)
                    rv[d*4 +: 4] = 4'(10 + $urandom_range(0, 5));
                else
                    rv[d*4 +: 4] = 4'($urandom_range(0, 9));
            end
            do_conv(rv);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
